// File: rtl/lsu_pkg.sv
// Shared types for the load/store request unit: op encoding, error codes,
// FSM states, the memory request payload and address-alignment helpers.
package lsu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned MASKW = 4;
  localparam int unsigned CNTW  = 8;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic             wen;
    logic [XLEN-1:0]  addr;
    logic [MASKW-1:0] wmask;
    logic [XLEN-1:0]  wdata;
  } mem_req_t;

  function automatic logic is_half(input op_e op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_word(input op_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_store(input op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic misaligned(input op_e op, input logic [1:0] lane);
    return (is_half(op) && lane[0]) || (is_word(op) && (lane != 2'b00));
  endfunction

  // Clear the low address bits that the access size requires to be zero.
  function automatic logic [XLEN-1:0] force_align(input op_e op, input logic [XLEN-1:0] addr);
    logic [XLEN-1:0] res;
    res = addr;
    if (is_half(op)) res[0] = 1'b0;
    if (is_word(op)) res[1:0] = 2'b00;
    return res;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/data shift toward memory and load lane
// extraction with sign/zero extension back from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  op_e              st_op,
  input  logic [1:0]       st_lane,
  input  logic [XLEN-1:0]  st_wdata,
  output logic [MASKW-1:0] st_wmask,
  output logic [XLEN-1:0]  st_wdata_sh,
  input  op_e              ld_op,
  input  logic [1:0]       ld_lane,
  input  logic [XLEN-1:0]  ld_rdata,
  output logic [XLEN-1:0]  ld_result
);

  logic [XLEN-1:0] lane_data;

  always_comb begin
    st_wmask    = '0;
    st_wdata_sh = st_wdata << {st_lane, 3'b000};
    case (st_op)
      OP_SB:   st_wmask = MASKW'(4'b0001 << st_lane);
      OP_SH:   st_wmask = MASKW'(4'b0011 << st_lane);
      OP_SW:   st_wmask = 4'b1111;
      default: st_wmask = '0;
    endcase
  end

  // Word loads are always lane 0, so the shifted word equals the raw word.
  always_comb begin
    lane_data = ld_rdata >> {ld_lane, 3'b000};
    ld_result = '0;
    case (ld_op)
      OP_LB:   ld_result = {{24{lane_data[7]}}, lane_data[7:0]};
      OP_LH:   ld_result = {{16{lane_data[15]}}, lane_data[15:0]};
      OP_LW:   ld_result = lane_data;
      OP_LBU:  ld_result = {24'h0, lane_data[7:0]};
      OP_LHU:  ld_result = {16'h0, lane_data[15:0]};
      default: ld_result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_req.sv
// Load/store request sequencer: accepts one pipeline request, issues it to
// memory, waits (with timeout) for the response and presents the result.
// LSU_MISALIGN_TRAP_EN: report misaligned accesses instead of force-aligning.
module lsu_req
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_addr,
  input  logic [XLEN-1:0]  in_wdata,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_wen,
  output logic [XLEN-1:0]  mem_req_addr,
  output logic [MASKW-1:0] mem_req_wmask,
  output logic [XLEN-1:0]  mem_req_wdata,
  input  logic             mem_resp_valid,
  input  logic [XLEN-1:0]  mem_resp_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_rdata,
  output logic [1:0]       out_err
);

  state_e           state;
  op_e              op_q;
  logic [1:0]       lane_q;
  logic [CNTW-1:0]  cnt;
  mem_req_t         mem_req_q;
  logic             mem_req_valid_q;
  logic             out_valid_q;
  logic [XLEN-1:0]  out_rdata_q;
  err_e             out_err_q;

  op_e              acc_op;
  logic [XLEN-1:0]  acc_addr;
  logic             acc_trap;
  logic [MASKW-1:0] acc_wmask;
  logic [XLEN-1:0]  acc_wdata;
  logic [XLEN-1:0]  ld_result;

  assign acc_op   = op_e'(in_op);
  assign acc_addr = force_align(acc_op, in_addr);

`ifdef LSU_MISALIGN_TRAP_EN
  assign acc_trap = misaligned(acc_op, in_addr[1:0]);
`else
  assign acc_trap = 1'b0;
`endif

  lsu_align u_align (
    .st_op       (acc_op),
    .st_lane     (acc_addr[1:0]),
    .st_wdata    (in_wdata),
    .st_wmask    (acc_wmask),
    .st_wdata_sh (acc_wdata),
    .ld_op       (op_q),
    .ld_lane     (lane_q),
    .ld_rdata    (mem_resp_rdata),
    .ld_result   (ld_result)
  );

  // Sequencer; memory payload is latched at accept so it stays stable in REQ.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      op_q            <= OP_LB;
      lane_q          <= '0;
      cnt             <= '0;
      mem_req_q       <= '0;
      mem_req_valid_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_rdata_q     <= '0;
      out_err_q       <= ERR_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q   <= acc_op;
            lane_q <= acc_addr[1:0];
            cnt    <= '0;
            if (acc_trap) begin
              state       <= ST_DONE;
              out_valid_q <= 1'b1;
              out_rdata_q <= '0;
              out_err_q   <= ERR_MISALIGN;
            end else begin
              state           <= ST_REQ;
              mem_req_valid_q <= 1'b1;
              mem_req_q       <= '{wen:   is_store(acc_op),
                                   addr:  {acc_addr[XLEN-1:2], 2'b00},
                                   wmask: acc_wmask,
                                   wdata: acc_wdata};
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            cnt             <= '0;
            state           <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            state       <= ST_DONE;
            out_valid_q <= 1'b1;
            out_rdata_q <= ld_result;
            out_err_q   <= ERR_OK;
          end else if (cnt == CNTW'(TIMEOUT_CYCLES - 1)) begin
            state       <= ST_DONE;
            out_valid_q <= 1'b1;
            out_rdata_q <= '0;
            out_err_q   <= ERR_TIMEOUT;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = (state == ST_IDLE);
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_wen   = mem_req_q.wen;
  assign mem_req_addr  = mem_req_q.addr;
  assign mem_req_wmask = mem_req_q.wmask;
  assign mem_req_wdata = mem_req_q.wdata;
  assign out_valid     = out_valid_q;
  assign out_rdata     = out_rdata_q;
  assign out_err       = out_err_q;

endmodule

// File: tb/tb_lsu_req.sv
// Directed bench for lsu_req: vector table of full transactions plus
// hand-written misalign, timeout, backpressure and reset sequences.
module tb_lsu_req;

  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3,
                         LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_wmask;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [1:0]  out_err;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  lsu_req #(.TIMEOUT_CYCLES(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_wen    (mem_req_wen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wmask  (mem_req_wmask),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rdata      (out_rdata),
    .out_err        (out_err)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_wen;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];
  int   nvec;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Full transaction with memory ready at once and response one cycle later.
  task automatic run_txn(input vec_t v, input string tag);
    in_valid = 1'b1; in_op = v.op; in_addr = v.addr; in_wdata = v.wdata;
    mem_req_ready = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, ".req_valid"}, 32'(mem_req_valid), 32'd1);
    chk({tag, ".wen"}, 32'(mem_req_wen), 32'(v.exp_wen));
    chk({tag, ".addr"}, mem_req_addr, v.exp_addr);
    chk({tag, ".wmask"}, 32'(mem_req_wmask), 32'(v.exp_wmask));
    if (v.exp_wen) chk({tag, ".wdata"}, mem_req_wdata, v.exp_wdata);
    tick();
    mem_req_ready = 1'b0;
    chk({tag, ".req_dropped"}, 32'(mem_req_valid), 32'd0);
    mem_resp_valid = 1'b1; mem_resp_rdata = v.rdata;
    chk({tag, ".early_out"}, 32'(out_valid), 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".rdata"}, out_rdata, v.exp_rdata);
    chk({tag, ".err"}, 32'(out_err), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".out_clear"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_addr = '0; in_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0; out_ready = 1'b0;

    //          op   addr          wdata         rdata         wen  exp_addr      mask     exp_wdata     exp_rdata
    vecs[0]  = '{SW,  32'h80000004, 32'hDEADBEEF, 32'h11111111, 1'b1, 32'h80000004, 4'b1111, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{LB,  32'h80000003, 32'h0,        32'h80FF1234, 1'b0, 32'h80000000, 4'b0000, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{LBU, 32'h80000003, 32'h0,        32'h80FF1234, 1'b0, 32'h80000000, 4'b0000, 32'h0,        32'h00000080};
    vecs[3]  = '{SH,  32'h80000002, 32'h0000ABCD, 32'h0,        1'b1, 32'h80000000, 4'b1100, 32'hABCD0000, 32'h0};
    vecs[4]  = '{LH,  32'h10000002, 32'h0,        32'h80017FFF, 1'b0, 32'h10000000, 4'b0000, 32'h0,        32'hFFFF8001};
    vecs[5]  = '{LHU, 32'h10000000, 32'h0,        32'h80017FFF, 1'b0, 32'h10000000, 4'b0000, 32'h0,        32'h00007FFF};
    vecs[6]  = '{LW,  32'h20000008, 32'h0,        32'h12345678, 1'b0, 32'h20000008, 4'b0000, 32'h0,        32'h12345678};
    vecs[7]  = '{SB,  32'h00000001, 32'h000000A5, 32'h0,        1'b1, 32'h00000000, 4'b0010, 32'h0000A500, 32'h0};
    vecs[8]  = '{LB,  32'h00000001, 32'h0,        32'h00007F00, 1'b0, 32'h00000000, 4'b0000, 32'h0,        32'h0000007F};
    vecs[9]  = '{SB,  32'h00000003, 32'h123456FF, 32'h0,        1'b1, 32'h00000000, 4'b1000, 32'hFF000000, 32'h0};
    vecs[10] = '{LHU, 32'h00000002, 32'h0,        32'hFEDC0000, 1'b0, 32'h00000000, 4'b0000, 32'h0,        32'h0000FEDC};
    vecs[11] = '{SW,  32'h0000000C, 32'hCAFEF00D, 32'h0,        1'b1, 32'h0000000C, 4'b1111, 32'hCAFEF00D, 32'h0};
    nvec = 12;

    tick(); tick();
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_rdata", out_rdata, 32'h0);
    chk("rst.out_err", 32'(out_err), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < nvec; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
    in_valid = 1'b1; in_op = LW; in_addr = 32'h80000001; in_wdata = '0; mem_req_ready = 1'b1;
    tick();
    in_valid = 1'b0; mem_req_ready = 1'b0;
    chk("mis.req_valid", 32'(mem_req_valid), 32'd0);
    chk("mis.out_valid", 32'(out_valid), 32'd1);
    chk("mis.err", 32'(out_err), 32'd1);
    chk("mis.rdata", out_rdata, 32'h0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("mis.clear", 32'(out_valid), 32'd0);
`else
    v = '{LW, 32'h80000001, 32'h0, 32'hCAFEF00D, 1'b0, 32'h80000000, 4'b0000, 32'h0, 32'hCAFEF00D};
    run_txn(v, "mis_lw");
    v = '{LH, 32'h00000003, 32'h0, 32'hBEEF0000, 1'b0, 32'h00000000, 4'b0000, 32'h0, 32'hFFFFBEEF};
    run_txn(v, "mis_lh");
    v = '{SH, 32'h00000001, 32'h00001234, 32'h0, 1'b1, 32'h00000000, 4'b0011, 32'h00001234, 32'h0};
    run_txn(v, "mis_sh");
`endif

    // Backpressure on the request, then timeout in WAIT
    in_valid = 1'b1; in_op = LW; in_addr = 32'h00000040; in_wdata = '0; mem_req_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("to.hold_valid%0d", i), 32'(mem_req_valid), 32'd1);
      chk($sformatf("to.hold_addr%0d", i), mem_req_addr, 32'h00000040);
      chk($sformatf("to.hold_wen%0d", i), 32'(mem_req_wen), 32'd0);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to.wait%0d", i), 32'(out_valid), 32'd0);
      tick();
    end
    chk("to.out_valid", 32'(out_valid), 32'd1);
    chk("to.err", 32'(out_err), 32'd2);
    chk("to.rdata", out_rdata, 32'h0);
    tick();
    chk("to.stall_valid", 32'(out_valid), 32'd1);
    chk("to.stall_err", 32'(out_err), 32'd2);
    chk("to.busy", 32'(in_ready), 32'd0);
    // A request offered during the out handshake must not be taken
    out_ready = 1'b1; in_valid = 1'b1; in_op = LW; in_addr = 32'h00000080;
    tick();
    out_ready = 1'b0;
    chk("to.no_accept", 32'(mem_req_valid), 32'd0);
    chk("to.idle", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    tick();

    // Reset while waiting for a response, then a stray response
    in_valid = 1'b1; in_op = LW; in_addr = 32'h00000050; mem_req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    mem_req_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw.in_ready", 32'(in_ready), 32'd1);
    chk("rw.out_valid", 32'(out_valid), 32'd0);
    chk("rw.req_valid", 32'(mem_req_valid), 32'd0);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h00000BAD;
    tick();
    mem_resp_valid = 1'b0;
    chk("rw.stray_out", 32'(out_valid), 32'd0);
    chk("rw.stray_rdata", out_rdata, 32'h0);
    tick();
    chk("rw.still_idle", 32'(in_ready), 32'd1);
    v = '{LW, 32'h00000060, 32'h0, 32'h600DF00D, 1'b0, 32'h00000060, 4'b0000, 32'h0, 32'h600DF00D};
    run_txn(v, "rw.next");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
